// File: rtl/index_countdown_sequencer_pkg.sv
// Shared types and constants for the index countdown sequencer.
package index_countdown_sequencer_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // All-ones idle marker for a given width; the caller casts it to its own width.
  function automatic logic [63:0] idle_marker(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/index_down_counter.sv
// Falling-edge down-counter with load, non-wrapping decrement and a zero flag.
module index_down_counter
  import index_countdown_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  dec,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  zero
);

  localparam logic [DATA_WIDTH-1:0] IDLE_VAL = DATA_WIDTH'(idle_marker(DATA_WIDTH));

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count <= IDLE_VAL;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - DATA_WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/index_countdown_sequencer.sv
// Valid/ready burst of indices N-1 down to 0; all-ones marks idle.
// Optional INDEX_COUNTDOWN_AUTO_RELOAD_EN repeats bursts until abort or rst.
module index_countdown_sequencer
  import index_countdown_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  abort,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  valid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DATA_WIDTH-1:0] IDLE_VAL = DATA_WIDTH'(idle_marker(DATA_WIDTH));

  state_t                state_q, state_d;
  logic                  cnt_load, cnt_dec, cnt_zero, done_d;
  logic [DATA_WIDTH-1:0] cnt_value;

`ifdef INDEX_COUNTDOWN_AUTO_RELOAD_EN
  logic [DATA_WIDTH-1:0] reload_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
    end else if ((state_q == IDLE) && load) begin
      reload_q <= load_value;
    end
  end
`endif

  index_down_counter #(.DATA_WIDTH(DATA_WIDTH)) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(cnt_value),
    .dec       (cnt_dec),
    .count     (out),
    .zero      (cnt_zero)
  );

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_value = IDLE_VAL;
    cnt_dec   = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          if (load_value == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_load  = 1'b1;
            cnt_value = load_value - DATA_WIDTH'(1);
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        // abort outranks a same-cycle transfer; counter reload restores the idle marker
        if (abort) begin
          cnt_load = 1'b1;
          state_d  = IDLE;
        end else if (ready_in) begin
          if (cnt_zero) begin
            done_d   = 1'b1;
            cnt_load = 1'b1;
`ifdef INDEX_COUNTDOWN_AUTO_RELOAD_EN
            cnt_value = reload_q - DATA_WIDTH'(1);
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // valid and busy come straight off the state flop, so they are glitch-free registered outputs
  assign valid = (state_q == RUN);
  assign busy  = (state_q == RUN);

endmodule

// File: doc/index_countdown_sequencer.md
Name: index_countdown_sequencer

Overview:
- Drains a burst of indices counting down from N-1 to 0; the mirror of the core's up-counting index counter, which idles at all 1's and wraps to 0 on its first increment.
- The scheduler loads a count N. The block presents indices N-1, N-2, ... 0 one per accepted transfer on a valid/ready interface to the downstream neuron/axon reader.
- It pulses done when index 0 is accepted, then returns to the all-1's idle value.

Parameters:
- DATA_WIDTH, 8, width of the index and of the load value.

Ports:
- clk  input  1  system clock; all state updates on the falling edge of clk.
- rst  input  1  reset, asynchronous, active-high; on assertion state goes immediately to reset values.
- load  input  1  start request; sampled only in IDLE.
- load_value  input  DATA_WIDTH  burst length N; sampled with load.
- abort  input  1  cancel the current burst; returns to IDLE with no done pulse.
- ready_in  input  1  downstream accepts out this cycle.
- out  output  DATA_WIDTH  current index.
- valid  output  1  out holds a valid index.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the final index is accepted, or after a zero-length load.

Behaviour:
- Reset values: state=IDLE, out={DATA_WIDTH{1'b1}}, valid=0, busy=0, done=0. Reset mid-burst discards the burst; no done pulse.
- States: IDLE, RUN. All outputs are registered; done defaults to 0 every cycle unless set below.
- IDLE, load=1, load_value=0: stay IDLE, done=1 next edge, out stays all 1's.
- IDLE, load=1, load_value=N>0: out<=N-1, valid<=1, busy<=1, go to RUN. Latency from load edge to first valid index is 1 edge.
- RUN, transfer occurs (valid&&ready_in) with out>0: out<=out-1, valid stays 1.
- RUN, transfer occurs with out==0: out<=all 1's, valid<=0, busy<=0, done<=1, go to IDLE.
- RUN, no transfer: out and valid hold (stable-until-accepted rule).
- load in RUN: ignored.
- abort in RUN: takes priority over a same-cycle transfer. Next edge: out<=all 1's, valid<=0, busy<=0, go to IDLE, done stays 0. abort in IDLE: no effect.
- Width rules:
  - N=2^DATA_WIDTH-1 (all 1's) emits 2^DATA_WIDTH-2 down to 0.
  - The all-1's index is never emitted; it is reserved as the idle marker.
  - The decrement never wraps below 0.
- A new burst may start with load on the edge immediately after done, since state is already IDLE.

Optional Feature:
- Macro: INDEX_COUNTDOWN_AUTO_RELOAD_EN.
- With it:
  - load_value is latched into an internal reload register on load.
  - When index 0 is accepted, done pulses, out<=reload-1, valid stays 1, and state stays RUN (continuous repeating bursts).
  - Only abort or rst returns to IDLE.
  - A latched N=0 behaves as without the macro.
- Without it: no reload register exists; behaviour is exactly as above.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN);
  - the idle-marker constant (all 1's of DATA_WIDTH) as a function of width;
  - the default DATA_WIDTH.
- One natural sub-module, index_down_counter: a falling-edge register with load, decrement-enable, and async-high reset to all 1's, plus a zero flag. The FSM wraps it.

Test Plan:
- Reset then idle: assert rst for 3 cycles -> out=8'hFF, valid=0, busy=0, done=0; hold load=0 for 10 cycles -> no change.
- Basic burst: load=1, load_value=4, ready_in=1 -> out sequence 3,2,1,0 on consecutive edges with valid=1; done=1 for exactly one cycle after index 0 is accepted; out=8'hFF, busy=0 after.
- Backpressure: load_value=3, ready_in toggles 1,0,0,1,1 -> out goes 2, holds 1 for two stalled cycles, then 0; no index skipped or duplicated; done after 0 is accepted.
- Edge lengths:
  - load_value=0 -> done pulse, valid never rises.
  - load_value=8'hFF -> 255 indices, 254 down to 0, 255 transfers total.
- Abort and reset mid-burst:
  - load_value=10; abort after 3 transfers with ready_in=1 the same cycle -> IDLE, out=8'hFF, done=0.
  - Repeat with async rst pulsed between clock edges -> outputs reset immediately.
- With INDEX_COUNTDOWN_AUTO_RELOAD_EN: load_value=2, ready_in=1 -> out 1,0,1,0,... with a done pulse after each 0; abort -> IDLE.
